// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: byte/half/word loads with extension, RMW sub-word stores, misalign faults
module lsu (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        misalign_o,
   output logic [31:0] mem_a_o,
   output logic [31:0] mem_wd_o,
   output logic        mem_we_o,
   input  logic [31:0] mem_rd_i
);

   typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP, S_FAULT} state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] rdata_q, rdata_d;

   logic        fault_w;
   logic [4:0]  lane_sh_w;
   logic [31:0] shifted_w;
   logic [31:0] load_val_w;
   logic [31:0] lane_mask_w;
   logic [31:0] merge_w;
   logic        wr_w;

   // Fault is decided from the live request since the IDLE edge both latches and branches on it.
   assign fault_w = (size_i == 2'b11)
                 || (size_i == SZ_HALF && addr_i[0])
                 || (size_i == SZ_WORD && addr_i[1:0] != 2'b00);

   assign lane_sh_w = {addr_q[1:0], 3'b000};
   assign shifted_w = mem_rd_i >> lane_sh_w;

   always_comb begin
      load_val_w  = mem_rd_i;
      lane_mask_w = 32'h0000_00FF;
      case (size_q)
         SZ_BYTE: load_val_w = {{24{sext_q & shifted_w[7]}}, shifted_w[7:0]};
         SZ_HALF: begin
            load_val_w  = {{16{sext_q & shifted_w[15]}}, shifted_w[15:0]};
            lane_mask_w = 32'h0000_FFFF;
         end
         default: load_val_w = mem_rd_i;
      endcase
   end

   assign merge_w = (mem_rd_i & ~(lane_mask_w << lane_sh_w))
                  | ((wdata_q & lane_mask_w) << lane_sh_w);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      size_d     = size_q;
      sext_d     = sext_q;
      wdata_d    = wdata_q;
      merge_d    = merge_q;
      rdata_d    = rdata_q;
      done_o     = 1'b0;
      misalign_o = 1'b0;
      mem_wd_o   = 32'h0;
      wr_w       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               addr_d  = addr_i;
               we_d    = we_i;
               size_d  = size_i;
               sext_d  = sign_ext_i;
               wdata_d = wdata_i;
               state_d = fault_w ? S_FAULT : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!we_q) begin
               rdata_d = load_val_w;
               state_d = S_RESP;
            end else if (size_q == SZ_WORD) begin
               wr_w     = 1'b1;
               mem_wd_o = wdata_q;
               state_d  = S_RESP;
            end else begin
               merge_d = merge_w;
               state_d = S_MERGE;
            end
         end
         S_MERGE: begin
            wr_w     = 1'b1;
            mem_wd_o = merge_q;
            state_d  = S_RESP;
         end
         S_RESP: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         S_FAULT: begin
            done_o     = 1'b1;
            misalign_o = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         addr_q  <= 32'h0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         wdata_q <= 32'h0;
         merge_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         wdata_q <= wdata_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
      end
   end

   // Gating by reset drops a write that would otherwise land on the reset edge.
   assign mem_we_o = wr_w & ~reset_i;
   assign mem_a_o  = addr_q;
   assign rdata_o  = rdata_q;
   assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with a word memory and reference model
module tb_lsu;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        sign_ext_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        done_o;
   logic        misalign_o;
   logic [31:0] mem_a_o;
   logic [31:0] mem_wd_o;
   logic        mem_we_o;
   logic [31:0] mem_rd_i;

   logic [31:0] dmem [64];
   logic [31:0] ref_mem [64];
   logic [31:0] exp_rdata;
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_data;

   int n_checks = 0;
   int n_fail   = 0;

   lsu dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .req_i      (req_i),
      .we_i       (we_i),
      .size_i     (size_i),
      .sign_ext_i (sign_ext_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .misalign_o (misalign_o),
      .mem_a_o    (mem_a_o),
      .mem_wd_o   (mem_wd_o),
      .mem_we_o   (mem_we_o),
      .mem_rd_i   (mem_rd_i)
   );

   always #5 clk_i = ~clk_i;

   assign mem_rd_i = dmem[mem_a_o[7:2]];

   always @(posedge clk_i) begin
      if (pl_en) dmem[pl_idx] <= pl_data;
      else if (mem_we_o) dmem[mem_a_o[7:2]] <= mem_wd_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] data);
      pl_en   = 1'b1;
      pl_idx  = idx[5:0];
      pl_data = data;
      ref_mem[idx] = data;
      @(posedge clk_i); #1;
      pl_en = 1'b0;
   endtask

   // Reference: expected fault, latency, write-cycle mask; updates ref_mem and exp_rdata.
   task automatic ref_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic f, output int n, output int wmask);
      int          idx;
      int          sh;
      logic [31:0] word;
      logic [31:0] v;
      logic [31:0] m;
      idx   = int'(a[7:2]);
      sh    = 8 * int'(a[1:0]);
      word  = ref_mem[idx];
      f     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      wmask = 0;
      if (f) begin
         n = 1;
      end else if (!w) begin
         n = 2;
         if (sz == 2'd0) begin
            v = (word >> sh) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
         end else if (sz == 2'd1) begin
            v = (word >> sh) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
         end else begin
            v = word;
         end
         exp_rdata = v;
      end else if (sz == 2'd2) begin
         n = 2;
         wmask = 1 << 1;
         ref_mem[idx] = wd;
      end else begin
         n = 3;
         wmask = 1 << 2;
         m = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
         ref_mem[idx] = (word & ~(m << sh)) | ((wd & m) << sh);
      end
   endtask

   task automatic do_op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
      logic f;
      int   n;
      int   mask;
      int   wm;
      int   got;
      logic busy_all;
      ref_op(w, sz, sx, a, wd, f, n, mask);
      check({tag, " busy_c0"}, {31'b0, busy_o}, 32'd0);
      req_i = 1'b1; we_i = w; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
      wm = mem_we_o ? 1 : 0;
      got = 0;
      busy_all = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk_i); #1;
         if (k == 1) begin
            req_i = 1'b0;
            addr_i = $urandom;
            wdata_i = $urandom;
         end
         if (mem_we_o) wm = wm | (1 << k);
         if (!busy_o) busy_all = 1'b0;
         if (done_o) begin
            got = k;
            break;
         end
      end
      check({tag, " latency"}, got, n);
      check({tag, " misalign"}, {31'b0, misalign_o}, {31'b0, f});
      check({tag, " we_cycles"}, wm, mask);
      check({tag, " busy"}, {31'b0, busy_all}, 32'd1);
      check({tag, " rdata"}, rdata_o, exp_rdata);
      check({tag, " memword"}, dmem[a[7:2]], ref_mem[a[7:2]]);
      @(posedge clk_i); #1;
   endtask

   initial begin
      int d1;
      int d2;
      reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sign_ext_i = 1'b0;
      addr_i = 32'h0; wdata_i = 32'h0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;
      exp_rdata = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst rdata", rdata_o, 32'h0);
      check("rst busy", {31'b0, busy_o}, 32'h0);
      check("rst done", {31'b0, done_o}, 32'h0);
      check("rst misalign", {31'b0, misalign_o}, 32'h0);
      check("rst mem_we", {31'b0, mem_we_o}, 32'h0);
      check("rst mem_a", mem_a_o, 32'h0);
      check("rst mem_wd", mem_wd_o, 32'h0);
      for (int i = 0; i < 64; i++) preload(i, $urandom);
      reset_i = 1'b0;
      @(posedge clk_i); #1;

      do_op("sw 0x10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      do_op("lw 0x10", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
      check("lw 0x10 value", rdata_o, 32'hDEADBEEF);

      preload(8, 32'h11223344);
      do_op("sb 0x22", 1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AB);
      check("sb 0x22 word", dmem[8], 32'h11AB3344);

      preload(12, 32'h80FF7F01);
      do_op("lb 0x32", 1'b0, 2'd0, 1'b1, 32'h32, 32'h0);
      check("lb value", rdata_o, 32'hFFFFFFFF);
      do_op("lbu 0x32", 1'b0, 2'd0, 1'b0, 32'h32, 32'h0);
      check("lbu value", rdata_o, 32'h000000FF);
      do_op("lh 0x32", 1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
      check("lh value", rdata_o, 32'hFFFF80FF);
      do_op("lhu 0x30", 1'b0, 2'd1, 1'b0, 32'h30, 32'h0);
      check("lhu value", rdata_o, 32'h00007F01);

      do_op("lh 0x31 fault", 1'b0, 2'd1, 1'b1, 32'h31, 32'h0);
      do_op("sw 0x2E fault", 1'b1, 2'd2, 1'b0, 32'h2E, 32'h12345678);
      do_op("size3 fault", 1'b1, 2'd3, 1'b0, 32'h0, 32'hCAFEF00D);
      check("fault rdata kept", rdata_o, 32'h00007F01);

      // Reset lands during the MERGE cycle of a byte store.
      preload(16, 32'h0);
      req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; sign_ext_i = 1'b0; addr_i = 32'h40; wdata_i = 32'h55;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      @(posedge clk_i); #1;
      check("rmw merge we", {31'b0, mem_we_o}, 32'd1);
      reset_i = 1'b1;
      #1;
      check("rmw reset gates we", {31'b0, mem_we_o}, 32'd0);
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      exp_rdata = 32'h0;
      check("rmw busy after rst", {31'b0, busy_o}, 32'd0);
      check("rmw done after rst", {31'b0, done_o}, 32'd0);
      check("rmw word 0x40", dmem[16], 32'h0);
      @(posedge clk_i); #1;
      check("rmw no late done", {31'b0, done_o}, 32'd0);
      check("rmw still idle", {31'b0, busy_o}, 32'd0);

      // req held high across two word loads.
      d1 = 0; d2 = 0;
      req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sign_ext_i = 1'b0; addr_i = 32'h10;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk_i); #1;
         if (k == 4) check("b2b mem_a 2nd", mem_a_o, 32'h14);
         if (done_o) begin
            if (d1 == 0) begin
               d1 = k;
               check("b2b rdata 1", rdata_o, ref_mem[4]);
               addr_i = 32'h14;
            end else begin
               d2 = k;
               check("b2b rdata 2", rdata_o, ref_mem[5]);
               req_i = 1'b0;
               break;
            end
         end
      end
      check("b2b done 1 cycle", d1, 32'd2);
      check("b2b done 2 cycle", d2, 32'd5);
      req_i = 1'b0;
      exp_rdata = ref_mem[5];
      @(posedge clk_i); #1;

      for (int i = 0; i < 150; i++) begin
         do_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
